burst_buffer: RTL and testbench
===============================

BURST_BUFFER -- requirements
Module: burst_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-002 SHALL have parameter LOC, default 16, storage depth in words; LOC == 2**ADD_WIDTH.
REQ-003 SHALL have parameter ADD_WIDTH, default 4, address width; pointers and count are ADD_WIDTH+1 bits.
REQ-004 SHALL have parameter BURST, default 4, words per read burst; 1 <= BURST <= LOC.
REQ-005 SHALL have one clock and a synchronous, active-high reset: all state updates on rising wclk; rst is sampled only at that edge.
REQ-006 wclk  input  1  single clock for write and read sides.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 wen  input  1  write strobe, one word per cycle.
REQ-009 din  input  DATA_WIDTH  write data.
REQ-010 ren  input  1  burst request, sampled only in IDLE.
REQ-011 flush  input  1  synchronous clear of contents and burst.
REQ-012 dout  output  DATA_WIDTH  registered read data.
REQ-013 dvalid  output  1  dout holds a valid burst word this cycle.
REQ-014 busy  output  1  high while state == RD.
REQ-015 full  output  1  count == LOC.
REQ-016 empty  output  1  count == 0.
REQ-017 count  output  ADD_WIDTH+1  words stored (wptr - rptr, modulo 2**(ADD_WIDTH+1)).
REQ-018 ovf  output  1  sticky: a write was dropped.

Function
REQ-019 Storage SHALL be a LOC-entry array; write address = wptr[ADD_WIDTH-1:0], read address = rptr[ADD_WIDTH-1:0]; pointer MSB is the wrap bit.
REQ-020 Write: wen && !full stores din at wptr and increments wptr; wen && full drops the word and sets ovf.
REQ-021 full, empty and count SHALL be derived from registered pointers; a write in a cycle where full is high is dropped even if a read occurs in that same cycle.
REQ-022 FSM states: IDLE, RD; beat counter of ceil(log2(BURST+1)) bits.
REQ-023 IDLE -> RD when ren && count >= BURST; beat counter cleared; otherwise IDLE is retained and ren is ignored (no partial bursts).
REQ-024 In each RD cycle: dout <= mem[rptr], rptr increments, dvalid <= 1, beat counter increments; after the BURST-th beat the FSM returns to IDLE.
REQ-025 Latency: ren accepted at edge N -> busy high N+1..N+BURST, dvalid/dout valid for exactly BURST consecutive cycles N+2..N+BURST+1.
REQ-026 ren during RD SHALL be ignored; a new burst requires ren sampled in IDLE (minimum 1 idle cycle between bursts).
REQ-027 dvalid SHALL be 0 in every cycle not covered by REQ-025; dout SHALL hold its last value when dvalid is 0.
REQ-028 Simultaneous accepted write and RD read in one cycle: count unchanged; write to the address being read returns old data only if the pointers differ (no bypass needed since count >= 1 in RD).
REQ-029 Pointer wrap: pointers increment modulo 2**(ADD_WIDTH+1); full/empty SHALL be correct across wrap.
REQ-030 flush: wptr = rptr = 0, ovf = 0, FSM -> IDLE, dvalid = 0 next cycle; wen/ren in the flush cycle are ignored; a burst in progress is aborted.
REQ-031 Priority: rst > flush > ren/wen.

Reset
REQ-032 On rst: wptr = rptr = 0, beat counter 0, FSM IDLE, dout = 0, dvalid = 0, busy = 0, ovf = 0, count = 0, empty = 1, full = 0.
REQ-033 Reset mid-burst SHALL abort the burst: dvalid = 0 the following cycle, no further beats; memory contents need not be cleared.

Verification
REQ-034 Reset then write 0x11,0x22,0x33,0x44, ren one cycle -> busy 4 cycles, dvalid 4 cycles starting 2 cycles after ren, dout 0x11,0x22,0x33,0x44, then count = 0, empty = 1.
REQ-035 Write 3 words, pulse ren -> no busy, no dvalid, count stays 3; write 4th, pulse ren -> 4-beat burst as REQ-025.
REQ-036 Write 17 words with no reads -> full = 1 after 16th, 17th dropped, ovf = 1, count = 16; flush -> count = 0, ovf = 0, empty = 1.
REQ-037 Fill 16, burst 4 while writing 4 new words concurrently -> count stays 16 through burst; repeat until >= 2 pointer wraps; data order matches write order, no loss.
REQ-038 rst asserted on 2nd beat of a burst -> dvalid = 0 next cycle, count = 0, busy = 0, further ren with count < 4 ignored.
REQ-039 flush on 3rd beat with wen high in same cycle -> burst aborted, write ignored, count = 0.

Source files
------------

// File: rtl/burst_buffer.sv
// burst_buffer: single-clock word FIFO that drains only in fixed-length bursts.
// Writes land one word per cycle. A burst of BURST registered words is launched
// from IDLE once at least BURST words are stored. Writes are dropped when full,
// and the sticky ovf flag records each drop.
module burst_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int LOC        = 16,
    parameter int ADD_WIDTH  = 4,
    parameter int BURST      = 4
) (
    input  logic                  wclk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  ren,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dvalid,
    output logic                  busy,
    output logic                  full,
    output logic                  empty,
    output logic [ADD_WIDTH:0]    count,
    output logic                  ovf
);

    localparam int BW = $clog2(BURST + 1);

    typedef enum logic {
        IDLE,
        RD
    } state_t;

    logic [DATA_WIDTH-1:0] mem_q [LOC];
    logic [ADD_WIDTH:0]    wptr_q, wptr_d;
    logic [ADD_WIDTH:0]    rptr_q, rptr_d;
    logic [ADD_WIDTH:0]    count_w;
    logic [BW-1:0]         beat_q;
    state_t                state_q;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  dvalid_q;
    logic                  ovf_q;
    logic                  full_w;
    logic                  wr_acc;
    logic                  rd_fire;

    // Occupancy is taken from the registered pointers only, so a write in a
    // cycle that starts full is dropped even if a beat frees a slot at the same edge.
    assign count_w = wptr_q - rptr_q;
    assign full_w  = (count_w == (ADD_WIDTH + 1)'(LOC));
    assign wr_acc  = wen && !full_w && !flush;
    assign rd_fire = (state_q == RD) && !flush;

    // Next pointer values for accepted writes and burst beats.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_acc) begin
            wptr_d = wptr_q + (ADD_WIDTH + 1)'(1);
        end
        if (rd_fire) begin
            rptr_d = rptr_q + (ADD_WIDTH + 1)'(1);
        end
    end

    // Storage array. Reset does not clear it; only the pointers are cleared.
    always_ff @(posedge wclk) begin
        if (!rst && wr_acc) begin
            mem_q[wptr_q[ADD_WIDTH-1:0]] <= din;
        end
    end

    // Pointer, overflow and burst FSM state with registered read outputs.
    always_ff @(posedge wclk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            beat_q   <= '0;
            state_q  <= IDLE;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (flush) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            beat_q   <= '0;
            state_q  <= IDLE;
            dvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (wen && full_w) begin
                ovf_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    dvalid_q <= 1'b0;
                    if (ren && (count_w >= (ADD_WIDTH + 1)'(BURST))) begin
                        state_q <= RD;
                        beat_q  <= '0;
                    end
                end
                RD: begin
                    dout_q   <= mem_q[rptr_q[ADD_WIDTH-1:0]];
                    dvalid_q <= 1'b1;
                    beat_q   <= beat_q + BW'(1);
                    if (beat_q == BW'(BURST - 1)) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    dvalid_q <= 1'b0;
                end
            endcase
        end
    end

    assign dout   = dout_q;
    assign dvalid = dvalid_q;
    assign busy   = (state_q == RD);
    assign full   = full_w;
    assign empty  = (count_w == '0);
    assign count  = count_w;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_burst_buffer.sv
// Testbench for burst_buffer: a table of hand-derived vectors, directed corner
// sequences, and randomized traffic checked against a queue-based model.
module tb_burst_buffer;

    localparam int DW  = 32;
    localparam int LOC = 16;
    localparam int AW  = 4;
    localparam int BST = 4;

    logic          wclk = 1'b0;
    logic          rst = 1'b0, wen = 1'b0, ren = 1'b0, flush = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic          dvalid, busy, full, empty, ovf;
    logic [AW:0]   count;

    int checks = 0;
    int errors = 0;

    burst_buffer #(
        .DATA_WIDTH(DW),
        .LOC(LOC),
        .ADD_WIDTH(AW),
        .BURST(BST)
    ) dut (
        .wclk(wclk), .rst(rst), .wen(wen), .din(din), .ren(ren), .flush(flush),
        .dout(dout), .dvalid(dvalid), .busy(busy), .full(full), .empty(empty),
        .count(count), .ovf(ovf)
    );

    always #5 wclk = ~wclk;

    // Reference model: stored words as a queue, plus the beats still owed.
    logic [DW-1:0] mq[$];
    int            owed = 0;
    logic          m_ovf = 1'b0;
    logic          m_dvalid = 1'b0;
    logic [DW-1:0] m_dout = '0;

    task automatic model_edge(input logic r, input logic f, input logic w,
                              input logic [DW-1:0] d, input logic rn);
        int sz;
        sz = mq.size();
        if (r) begin
            mq.delete(); owed = 0; m_ovf = 1'b0; m_dvalid = 1'b0; m_dout = '0;
        end else if (f) begin
            mq.delete(); owed = 0; m_ovf = 1'b0; m_dvalid = 1'b0;
        end else begin
            if (owed > 0) begin
                m_dout = mq.pop_front();
                m_dvalid = 1'b1;
                owed--;
            end else begin
                m_dvalid = 1'b0;
                if (rn && sz >= BST) owed = BST;
            end
            if (w) begin
                if (sz < LOC) mq.push_back(d);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive on the falling edge, advance the model at the rising
    // edge, then leave 1 time unit before any sampling.
    task automatic step(input logic r, input logic f, input logic w,
                        input logic [DW-1:0] d, input logic rn);
        @(negedge wclk);
        rst = r; flush = f; wen = w; din = d; ren = rn;
        @(posedge wclk);
        model_edge(r, f, w, d, rn);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".count"}, 64'(count), 64'(mq.size()));
        chk({tag, ".empty"}, 64'(empty), 64'(mq.size() == 0));
        chk({tag, ".full"}, 64'(full), 64'(mq.size() == LOC));
        chk({tag, ".busy"}, 64'(busy), 64'(owed > 0));
        chk({tag, ".dvalid"}, 64'(dvalid), 64'(m_dvalid));
        chk({tag, ".ovf"}, 64'(ovf), 64'(m_ovf));
        if (m_dvalid) chk({tag, ".dout"}, 64'(dout), 64'(m_dout));
    endtask

    typedef struct {
        logic          r, f, w, rn;
        logic [DW-1:0] d;
        logic [AW:0]   cnt;
        logic          bsy, dv;
        logic [DW-1:0] dq;
        logic          emp, ful, ov;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic f, input logic w,
                                input logic [DW-1:0] d, input logic rn,
                                input int cnt, input logic bsy, input logic dv,
                                input logic [DW-1:0] dq);
        vec_t v;
        v.r = r; v.f = f; v.w = w; v.d = d; v.rn = rn;
        v.cnt = (AW + 1)'(cnt); v.bsy = bsy; v.dv = dv; v.dq = dq;
        v.emp = (cnt == 0); v.ful = (cnt == LOC); v.ov = 1'b0;
        return v;
    endfunction

    vec_t tbl[22];

    initial begin
        // Expected outputs one edge after each row's inputs are applied.
        tbl[0]  = mk(1, 0, 0, 32'h00, 0, 0, 0, 0, 32'h00);
        tbl[1]  = mk(0, 0, 1, 32'h11, 0, 1, 0, 0, 32'h00);
        tbl[2]  = mk(0, 0, 1, 32'h22, 0, 2, 0, 0, 32'h00);
        tbl[3]  = mk(0, 0, 1, 32'h33, 0, 3, 0, 0, 32'h00);
        tbl[4]  = mk(0, 0, 1, 32'h44, 0, 4, 0, 0, 32'h00);
        tbl[5]  = mk(0, 0, 0, 32'h00, 1, 4, 1, 0, 32'h00);
        tbl[6]  = mk(0, 0, 0, 32'h00, 0, 3, 1, 1, 32'h11);
        tbl[7]  = mk(0, 0, 0, 32'h00, 0, 2, 1, 1, 32'h22);
        tbl[8]  = mk(0, 0, 0, 32'h00, 0, 1, 1, 1, 32'h33);
        tbl[9]  = mk(0, 0, 0, 32'h00, 0, 0, 0, 1, 32'h44);
        tbl[10] = mk(0, 0, 0, 32'h00, 0, 0, 0, 0, 32'h44);
        tbl[11] = mk(0, 0, 1, 32'h55, 0, 1, 0, 0, 32'h44);
        tbl[12] = mk(0, 0, 1, 32'h66, 0, 2, 0, 0, 32'h44);
        tbl[13] = mk(0, 0, 1, 32'h77, 0, 3, 0, 0, 32'h44);
        tbl[14] = mk(0, 0, 0, 32'h00, 1, 3, 0, 0, 32'h44);
        tbl[15] = mk(0, 0, 1, 32'h88, 0, 4, 0, 0, 32'h44);
        tbl[16] = mk(0, 0, 0, 32'h00, 1, 4, 1, 0, 32'h44);
        tbl[17] = mk(0, 0, 0, 32'h00, 1, 3, 1, 1, 32'h55);
        tbl[18] = mk(0, 0, 0, 32'h00, 1, 2, 1, 1, 32'h66);
        tbl[19] = mk(0, 0, 0, 32'h00, 0, 1, 1, 1, 32'h77);
        tbl[20] = mk(0, 0, 0, 32'h00, 0, 0, 0, 1, 32'h88);
        tbl[21] = mk(0, 0, 0, 32'h00, 1, 0, 0, 0, 32'h88);

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].r, tbl[i].f, tbl[i].w, tbl[i].d, tbl[i].rn);
            chk($sformatf("tbl%0d.count", i), 64'(count), 64'(tbl[i].cnt));
            chk($sformatf("tbl%0d.busy", i), 64'(busy), 64'(tbl[i].bsy));
            chk($sformatf("tbl%0d.dvalid", i), 64'(dvalid), 64'(tbl[i].dv));
            chk($sformatf("tbl%0d.dout", i), 64'(dout), 64'(tbl[i].dq));
            chk($sformatf("tbl%0d.empty", i), 64'(empty), 64'(tbl[i].emp));
            chk($sformatf("tbl%0d.full", i), 64'(full), 64'(tbl[i].ful));
            chk($sformatf("tbl%0d.ovf", i), 64'(ovf), 64'(tbl[i].ov));
        end

        // Overflow: 17 writes into a 16-word store, then flush.
        step(1, 0, 0, '0, 0);
        for (int i = 0; i < 17; i++) begin
            step(0, 0, 1, 32'hA000 + 32'(i), 0);
            if (i == 15) chk("ovf.full_after_16", 64'(full), 64'd1);
            check_model($sformatf("ovf%0d", i));
        end
        chk("ovf.sticky", 64'(ovf), 64'd1);
        chk("ovf.count16", 64'(count), 64'd16);
        step(0, 1, 1, 32'hDEAD, 1);
        chk("flush.count", 64'(count), 64'd0);
        chk("flush.ovf", 64'(ovf), 64'd0);
        chk("flush.empty", 64'(empty), 64'd1);

        // Sustained bursts from a full store with refill writes, across pointer wraps.
        // The first beat starts full, so its write would be dropped; the refill
        // is shifted to beats 2..4 plus the following idle cycle.
        step(1, 0, 0, '0, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 32'hB000 + 32'(i), 0);
        for (int b = 0; b < 20; b++) begin
            step(0, 0, 0, '0, 1);
            check_model($sformatf("wrap%0d.acc", b));
            step(0, 0, 0, '0, 0);
            check_model($sformatf("wrap%0d.b1", b));
            for (int k = 0; k < 4; k++) begin
                step(0, 0, 1, $urandom, 0);
                check_model($sformatf("wrap%0d.w%0d", b, k));
            end
        end
        chk("wrap.no_ovf", 64'(ovf), 64'd0);

        // Reset on the 2nd beat aborts the burst.
        step(1, 0, 0, '0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 32'hC000 + 32'(i), 0);
        step(0, 0, 0, '0, 1);
        step(0, 0, 0, '0, 0);
        chk("rstmid.beat1", 64'(dout), 64'hC000);
        step(1, 0, 0, '0, 0);
        chk("rstmid.dvalid", 64'(dvalid), 64'd0);
        chk("rstmid.busy", 64'(busy), 64'd0);
        chk("rstmid.count", 64'(count), 64'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 32'hC100 + 32'(i), 0);
        step(0, 0, 0, '0, 1);
        chk("rstmid.ren_ignored", 64'(busy), 64'd0);
        step(0, 0, 0, '0, 0);
        chk("rstmid.no_beat", 64'(dvalid), 64'd0);
        check_model("rstmid");

        // Flush with a write on the 3rd beat.
        step(1, 0, 0, '0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 32'hD000 + 32'(i), 0);
        step(0, 0, 0, '0, 1);
        step(0, 0, 0, '0, 0);
        step(0, 0, 0, '0, 0);
        step(0, 1, 1, 32'hEEEE, 0);
        chk("flushmid.count", 64'(count), 64'd0);
        chk("flushmid.dvalid", 64'(dvalid), 64'd0);
        chk("flushmid.busy", 64'(busy), 64'd0);
        chk("flushmid.dout_held", 64'(dout), 64'hD001);
        step(0, 0, 0, '0, 0);
        chk("flushmid.after", 64'(dvalid), 64'd0);
        check_model("flushmid");

        // Randomized traffic with varying write pressure.
        step(1, 0, 0, '0, 0);
        for (int blk = 0; blk < 6; blk++) begin
            int wp;
            wp = (blk % 3 == 0) ? 90 : ((blk % 3 == 1) ? 20 : 55);
            for (int c = 0; c < 500; c++) begin
                logic r, f, w, rn;
                r  = ($urandom_range(0, 299) == 0);
                f  = ($urandom_range(0, 149) == 0);
                w  = ($urandom_range(0, 99) < wp);
                rn = ($urandom_range(0, 2) == 0);
                step(r, f, w, $urandom, rn);
                check_model($sformatf("rnd%0d_%0d", blk, c));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
